// File: rtl/bip_pkg.sv
// Shared definitions for the bip processor / debug subsystem:
// default RAM geometry and the RAM arbiter state encoding.
package bip_pkg;

    localparam int DEF_NB_INSTRUCTION = 16;
    localparam int DEF_NB_ADDR        = 11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_GRANT = 2'd1,
        ST_RESP  = 2'd2
    } arb_state_e;

endpackage

// File: rtl/ram_arbiter.sv
// Shares the single-port program RAM between the CPU and the debug unit.
// The CPU owns the port except for one stolen GRANT cycle per debug access.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   ST_IDLE  | CPU drives RAM; debug request waits while CPU is busy
//   ST_GRANT | debug drives RAM for one cycle, CPU stalled
//   ST_RESP  | CPU drives RAM again; ack pulses, debug read data returned
module ram_arbiter
    import bip_pkg::*;
#(
    parameter int NB_INSTRUCTION = DEF_NB_INSTRUCTION,
    parameter int NB_ADDR        = DEF_NB_ADDR,
    parameter int MAX_WAIT       = 8
) (
    input  logic                      i_clock,
    input  logic                      i_reset,
    input  logic [NB_ADDR-1:0]        i_cpu_addr,
    input  logic [NB_INSTRUCTION-1:0] i_cpu_data,
    input  logic                      i_cpu_wr_enable,
    input  logic                      i_cpu_rd_enable,
    output logic [NB_INSTRUCTION-1:0] o_cpu_data,
    output logic                      o_cpu_stall,
    input  logic                      i_dbg_req,
    input  logic                      i_dbg_we,
    input  logic [NB_ADDR-1:0]        i_dbg_addr,
    input  logic [NB_INSTRUCTION-1:0] i_dbg_data,
    output logic                      o_dbg_ack,
    output logic [NB_INSTRUCTION-1:0] o_dbg_data,
    output logic [NB_ADDR-1:0]        o_ram_addr,
    output logic [NB_INSTRUCTION-1:0] o_ram_data,
    output logic                      o_ram_wr_enable,
    output logic                      o_ram_rd_enable,
    input  logic [NB_INSTRUCTION-1:0] i_ram_data
);

    localparam int                WAIT_W   = $clog2(MAX_WAIT + 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);

    arb_state_e                state_q, state_d;
    logic [WAIT_W-1:0]         wait_cnt_q, wait_cnt_d;
    logic                      dbg_we_q, dbg_we_d;
    logic [NB_INSTRUCTION-1:0] dbg_data_q, dbg_data_d;
    logic                      cpu_busy;

    assign cpu_busy   = i_cpu_wr_enable | i_cpu_rd_enable;
    assign o_cpu_data = i_ram_data;

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            wait_cnt_q <= '0;
            dbg_we_q   <= 1'b0;
            dbg_data_q <= '0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            dbg_we_q   <= dbg_we_d;
            dbg_data_q <= dbg_data_d;
        end
    end

    always_comb begin
        state_d         = state_q;
        wait_cnt_d      = '0;
        dbg_we_d        = dbg_we_q;
        dbg_data_d      = dbg_data_q;
        o_ram_addr      = i_cpu_addr;
        o_ram_data      = i_cpu_data;
        o_ram_wr_enable = i_cpu_wr_enable;
        o_ram_rd_enable = i_cpu_rd_enable;
        o_cpu_stall     = 1'b0;
        o_dbg_ack       = 1'b0;
        o_dbg_data      = dbg_data_q;

        case (state_q)
            ST_IDLE: begin
                if (i_dbg_req) begin
                    if (!cpu_busy || wait_cnt_q == WAIT_MAX) begin
                        state_d = ST_GRANT;
                    end else begin
                        wait_cnt_d = wait_cnt_q + WAIT_W'(1);
                    end
                end
            end
            ST_GRANT: begin
                o_ram_addr      = i_dbg_addr;
                o_ram_data      = i_dbg_data;
                o_ram_wr_enable = i_dbg_we;
                o_ram_rd_enable = !i_dbg_we;
                o_cpu_stall     = 1'b1;
                dbg_we_d        = i_dbg_we;
                state_d         = ST_RESP;
            end
            ST_RESP: begin
                // Read data arrives this cycle; present it with the ack and keep it afterwards.
                o_dbg_ack = 1'b1;
                if (!dbg_we_q) begin
                    o_dbg_data = i_ram_data;
                    dbg_data_d = i_ram_data;
                end
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

endmodule

// File: tb/tb_ram_arbiter.sv
// Bench for ram_arbiter: a registered-read RAM, a cycle-timeline reference model
// checked every cycle, directed scenarios with literal expectations, random traffic.
module tb_ram_arbiter;

    localparam int NI = 16;
    localparam int NA = 11;
    localparam int MW = 8;

    logic          clk = 1'b0;
    logic          rst;
    logic [NA-1:0] cpu_addr;
    logic [NI-1:0] cpu_wdata;
    logic          cpu_we, cpu_re;
    logic [NI-1:0] cpu_rdata;
    logic          stall;
    logic          dbg_req, dbg_we;
    logic [NA-1:0] dbg_addr;
    logic [NI-1:0] dbg_wdata;
    logic          dbg_ack;
    logic [NI-1:0] dbg_rdata;
    logic [NA-1:0] ram_addr;
    logic [NI-1:0] ram_wdata;
    logic          ram_we, ram_re;
    logic [NI-1:0] ram_q = '0;
    logic [NI-1:0] ram_mem [0:(1<<NA)-1] = '{default: '0};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    ram_arbiter #(
        .NB_INSTRUCTION(NI),
        .NB_ADDR       (NA),
        .MAX_WAIT      (MW)
    ) dut (
        .i_clock        (clk),
        .i_reset        (rst),
        .i_cpu_addr     (cpu_addr),
        .i_cpu_data     (cpu_wdata),
        .i_cpu_wr_enable(cpu_we),
        .i_cpu_rd_enable(cpu_re),
        .o_cpu_data     (cpu_rdata),
        .o_cpu_stall    (stall),
        .i_dbg_req      (dbg_req),
        .i_dbg_we       (dbg_we),
        .i_dbg_addr     (dbg_addr),
        .i_dbg_data     (dbg_wdata),
        .o_dbg_ack      (dbg_ack),
        .o_dbg_data     (dbg_rdata),
        .o_ram_addr     (ram_addr),
        .o_ram_data     (ram_wdata),
        .o_ram_wr_enable(ram_we),
        .o_ram_rd_enable(ram_re),
        .i_ram_data     (ram_q)
    );

    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_q <= ram_mem[ram_addr];
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors <= 30)
                $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: a debug access is decided at cycle d (first cycle with req where
    // the CPU is idle, or MAX_WAIT cycles after the request window opened), owns the
    // port at d+1 and acks at d+2. RAM contents are tracked in a shadow array.
    logic [NI-1:0] shadow [0:(1<<NA)-1] = '{default: '0};
    logic [NI-1:0] m_q    = '0;
    logic [NI-1:0] m_last = '0;
    logic          m_gwe  = 1'b0;
    int            m_cyc  = 0;
    int            m_dec  = -100;
    int            m_pend = -1;

    always @(negedge clk) begin
        logic [NA-1:0] e_addr;
        logic [NI-1:0] e_wd, nq;
        logic          e_we, e_re, e_stall, e_ack;
        e_addr  = cpu_addr;
        e_wd    = cpu_wdata;
        e_we    = cpu_we;
        e_re    = cpu_re;
        e_stall = 1'b0;
        e_ack   = 1'b0;
        if (rst) begin
            m_dec  = -100;
            m_pend = -1;
            m_last = '0;
        end else if (m_cyc == m_dec + 1) begin
            e_addr  = dbg_addr;
            e_wd    = dbg_wdata;
            e_we    = dbg_we;
            e_re    = !dbg_we;
            e_stall = 1'b1;
            m_gwe   = dbg_we;
        end else if (m_cyc == m_dec + 2) begin
            e_ack = 1'b1;
            if (!m_gwe) m_last = m_q;
        end else if (dbg_req) begin
            if (m_pend < 0) m_pend = m_cyc;
            if (!(cpu_we || cpu_re) || (m_cyc - m_pend) == MW) begin
                m_dec  = m_cyc;
                m_pend = -1;
            end
        end else begin
            m_pend = -1;
        end

        chk("ram_port", 64'({ram_addr, ram_wdata, ram_we, ram_re}), 64'({e_addr, e_wd, e_we, e_re}));
        chk("cpu_stall", 64'(stall), 64'(e_stall));
        chk("dbg_ack", 64'(dbg_ack), 64'(e_ack));
        chk("dbg_data", 64'(dbg_rdata), 64'(m_last));
        chk("cpu_data", 64'(cpu_rdata), 64'(m_q));

        nq = e_re ? shadow[e_addr] : m_q;
        if (e_we) shadow[e_addr] = e_wd;
        m_q = nq;
        m_cyc++;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cpu();
        cpu_we = 1'b0;
        cpu_re = 1'b0;
    endtask

    // Called just after a rising edge; the current cycle is offset 0.
    task automatic dbg_txn(input logic we, input logic [NA-1:0] a, input logic [NI-1:0] d,
                           input bit keep_reading, output int ack_off, output int stalls,
                           output logic [NI-1:0] rd);
        ack_off   = -1;
        stalls    = 0;
        rd        = '0;
        dbg_req   = 1'b1;
        dbg_we    = we;
        dbg_addr  = a;
        dbg_wdata = d;
        for (int n = 0; n < MW + 6; n++) begin
            @(negedge clk);
            if (stall) stalls++;
            if (dbg_ack) begin
                ack_off = n;
                rd      = dbg_rdata;
            end
            tick();
            if (keep_reading) begin
                cpu_re   = 1'b1;
                cpu_we   = 1'b0;
                cpu_addr = NA'($urandom_range(16, 31));
            end else begin
                idle_cpu();
            end
            if (ack_off >= 0) break;
        end
        dbg_req = 1'b0;
    endtask

    initial begin
        int            off, st, acks, age, hold_off, rnd;
        logic [NI-1:0] rd;
        bit            drop;

        rst       = 1'b1;
        cpu_addr  = NA'(7);
        cpu_wdata = '0;
        cpu_we    = 1'b0;
        cpu_re    = 1'b1;
        dbg_req   = 1'b0;
        dbg_we    = 1'b0;
        dbg_addr  = '0;
        dbg_wdata = '0;
        tick();
        @(negedge clk);
        chk("reset_stall", 64'(stall), 64'd0);
        chk("reset_ack", 64'(dbg_ack), 64'd0);
        chk("reset_dbg_data", 64'(dbg_rdata), 64'd0);
        chk("reset_ram_follows_cpu", 64'({ram_addr, ram_re}), 64'({11'd7, 1'b1}));
        tick();
        rst = 1'b0;
        idle_cpu();

        cpu_we    = 1'b1;
        cpu_addr  = NA'(5);
        cpu_wdata = 16'h1234;
        tick();
        idle_cpu();
        tick();

        dbg_txn(1'b0, NA'(5), '0, 1'b0, off, st, rd);
        chk("idle_read_ack_offset", 64'(off), 64'd2);
        chk("idle_read_stalls", 64'(st), 64'd1);
        chk("idle_read_data", 64'(rd), 64'h1234);

        cpu_re   = 1'b1;
        cpu_addr = NA'(20);
        dbg_txn(1'b0, NA'(5), '0, 1'b1, off, st, rd);
        idle_cpu();
        chk("busy_read_ack_offset", 64'(off), 64'(MW + 2));
        chk("busy_read_stalls", 64'(st), 64'd1);
        chk("busy_read_data", 64'(rd), 64'h1234);

        dbg_txn(1'b1, NA'('hA), 16'hBEEF, 1'b0, off, st, rd);
        chk("dbg_write_ack_offset", 64'(off), 64'd2);
        cpu_re   = 1'b1;
        cpu_addr = NA'('hA);
        tick();
        idle_cpu();
        @(negedge clk);
        chk("cpu_sees_dbg_write", 64'(cpu_rdata), 64'hBEEF);
        tick();

        cpu_we    = 1'b1;
        cpu_addr  = NA'(3);
        cpu_wdata = 16'h1111;
        dbg_txn(1'b1, NA'(3), 16'h2222, 1'b0, off, st, rd);
        chk("collide_ack_offset", 64'(off), 64'd3);
        cpu_re   = 1'b1;
        cpu_addr = NA'(3);
        tick();
        idle_cpu();
        @(negedge clk);
        chk("collide_dbg_wins", 64'(cpu_rdata), 64'h2222);
        tick();

        dbg_req  = 1'b1;
        dbg_we   = 1'b0;
        dbg_addr = NA'(5);
        tick();
        rst     = 1'b1;
        dbg_req = 1'b0;
        @(negedge clk);
        chk("reset_in_grant_stall", 64'(stall), 64'd0);
        acks = 0;
        tick();
        rst = 1'b0;
        for (int n = 0; n < 5; n++) begin
            @(negedge clk);
            if (dbg_ack) acks++;
            tick();
        end
        chk("reset_in_grant_no_ack", 64'(acks), 64'd0);

        dbg_txn(1'b0, NA'(5), '0, 1'b0, off, st, rd);
        chk("b2b_first_ack_offset", 64'(off), 64'd2);
        dbg_txn(1'b0, NA'('hA), '0, 1'b0, off, st, rd);
        chk("b2b_second_ack_offset", 64'(off), 64'd2);
        chk("b2b_second_stalls", 64'(st), 64'd1);
        chk("b2b_second_data", 64'(rd), 64'hBEEF);

        age      = 0;
        hold_off = 0;
        for (int n = 0; n < 3000; n++) begin
            rnd       = int'($urandom_range(0, 9));
            cpu_re    = (rnd < 4);
            cpu_we    = (rnd >= 4 && rnd < 6);
            cpu_addr  = NA'($urandom_range(0, 15));
            cpu_wdata = NI'($urandom);
            if (!dbg_req && hold_off == 0 && $urandom_range(0, 2) == 0) begin
                dbg_req   = 1'b1;
                dbg_we    = 1'($urandom_range(0, 1));
                dbg_addr  = NA'($urandom_range(0, 15));
                dbg_wdata = NI'($urandom);
                age       = 0;
            end
            if (hold_off > 0) hold_off--;
            @(negedge clk);
            drop = 1'b0;
            if (dbg_req) begin
                if (dbg_ack) begin
                    chk("dbg_ack_within_bound", 64'(age <= MW + 2), 64'd1);
                    drop = 1'b1;
                end else if (age > MW + 2) begin
                    chk("dbg_ack_timeout", 64'(age), 64'(MW + 2));
                    drop = 1'b1;
                end else if (stall && $urandom_range(0, 3) == 0) begin
                    drop     = 1'b1;
                    hold_off = 1;
                end
                age++;
            end
            tick();
            if (drop) begin
                dbg_req = 1'b0;
                if (hold_off > 0) begin
                    dbg_we    = 1'($urandom_range(0, 1));
                    dbg_addr  = NA'($urandom_range(0, 15));
                    dbg_wdata = NI'($urandom);
                end
            end
        end

        dbg_req = 1'b0;
        idle_cpu();
        tick();
        tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
